rr_arbiter4_enc: RTL

Round-robin arbiter that shares one downstream resource between four requesters and reports the winner both one-hot and as a 2-bit encoded index. It is the sequencing front-end for the 4:2 encoder datapath: it turns raw, possibly simultaneous request lines into a single, held, fairly rotated grant. It adds grant locking, a hold-time limit, and a global enable whose disabled behaviour matches the encoder's (all outputs zero).

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_pick4.sv | 34 +++
 rtl/rr_arbiter4_enc.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   N_REQ   : number of requesters
//   ID_W    : width of an encoded requester index
//   state_t : arbiter FSM states (IDLE, GRANT)
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request bit found when scanning
// from ptr upward, modulo 4.
// Ports:
//   req        in  [3:0]  request lines
//   ptr        in  [1:0]  index that has highest priority this cycle
//   pick_id    out [1:0]  index of the selected requester (0 when none)
//   pick_valid out        high when any request is present
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  pick_id,
    output logic             pick_valid
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest offset back toward ptr so the closest set bit
    // is the last one written and therefore wins. The ID_W-bit add wraps
    // modulo 4 by itself.
    always_comb begin
        pick_id    = '0;
        pick_valid = |req;
        idx        = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) begin
                pick_id = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4_enc.sv
// Round-robin arbiter for four requesters with held grants, a hold-time limit
// under contention, and a global enable. Every output is a register.
// Parameters:
//   MAX_HOLD   maximum consecutive grant cycles while another requester waits (>= 2)
// Ports:
//   clk        in         rising-edge clock
//   rst_n      in         asynchronous active-low reset
//   en         in         arbitration enable; low forces idle
//   req        in  [3:0]  request lines, bit i belongs to requester i
//   gnt        out [3:0]  one-hot grant
//   gnt_id     out [1:0]  encoded index of the granted requester, 0 when idle
//   gnt_valid  out        high while a grant is active (equals |gnt)
//   timeout    out        one-cycle pulse in the idle cycle after a hold-limit revoke
module rr_arbiter4_enc
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [ID_W-1:0]  ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [ID_W-1:0]  gnt_id_nxt;
    logic             gnt_valid_nxt;
    logic             timeout_nxt;

    logic [ID_W-1:0]  pick_id;
    logic             pick_valid;
    logic             owner_req;
    logic             competitor;
    logic             hold_expired;

    rr_pick4 u_pick (
        .req        (req),
        .ptr        (ptr),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    // gnt is one-hot, so it doubles as the mask that hides the owner's bit
    // when looking for someone else waiting.
    assign owner_req    = req[gnt_id];
    assign competitor   = |(req & ~gnt);
    assign hold_expired = (hold_cnt == HOLD_LAST) && competitor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en && pick_valid) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!en || !owner_req || hold_expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the output registers, pointer and hold counter. Any
    // exit from GRANT leaves the outputs at their zero defaults, which
    // produces the mandatory idle cycle between grants.
    always_comb begin
        gnt_nxt       = '0;
        gnt_id_nxt    = '0;
        gnt_valid_nxt = 1'b0;
        timeout_nxt   = 1'b0;
        ptr_nxt       = ptr;
        hold_cnt_nxt  = '0;
        case (state)
            IDLE: begin
                if (en && pick_valid) begin
                    gnt_nxt[pick_id] = 1'b1;
                    gnt_id_nxt       = pick_id;
                    gnt_valid_nxt    = 1'b1;
                end
            end
            GRANT: begin
                if (!en) begin
                    // Disable keeps the pointer, so the same requester is
                    // favoured again once enabled.
                    ptr_nxt = ptr;
                end else if (!owner_req) begin
                    ptr_nxt = gnt_id + ID_W'(1);
                end else if (hold_expired) begin
                    ptr_nxt     = gnt_id + ID_W'(1);
                    timeout_nxt = 1'b1;
                end else begin
                    gnt_nxt       = gnt;
                    gnt_id_nxt    = gnt_id;
                    gnt_valid_nxt = 1'b1;
                    // Saturate so an uncontended owner stays at the limit
                    // and is revoked as soon as a competitor shows up.
                    hold_cnt_nxt  = (hold_cnt == HOLD_LAST) ? hold_cnt
                                                            : hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                ptr_nxt = ptr;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
        end
    end

endmodule
